// File: rtl/cpu_step_ctrl.sv
// Run/step controller: debounces the front-panel button and gates the CPU
// clock enable for single-cycle, single-instruction, free-run and breakpoint.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   btn         raw push-button, asynchronous to clk
//   mode        00 step cycle, 01 step instr, 10 run, 11 run-to-breakpoint
//   bp_addr     breakpoint PC
//   pc          current PC from the core
//   ctrl_state  current core controller state
//   halt_req    synchronous halt request (level)
//   cpu_ce      clock enable for all CPU sequential state
//   btn_pulse   one-cycle pulse on debounced rising edge
//   busy        high while stepping or running
//   bp_hit      current HALT was caused by the breakpoint
//   cycle_count number of enabled CPU cycles
//   instr_count number of enabled fetch cycles
module cpu_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0]  FETCH_STATE     = 4'd0,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [1:0]  mode,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [3:0]  ctrl_state,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic        btn_pulse,
    output logic        busy,
    output logic        bp_hit,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP_CYC,
        S_STEP_INSTR,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] db_cnt_q;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic        issued_q;
    logic        bp_hit_q;
    logic [31:0] cyc_q;
    logic [31:0] ins_q;

    logic is_fetch;
    logic bp_match;
    logic halt_force;

    // Debounce: the accepted level only moves after DEBOUNCE_CYCLES
    // consecutive synchronized samples that disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
            if (sync2_q == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_q <= '0;
                level_q  <= sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        is_fetch   = (ctrl_state == FETCH_STATE);
        bp_match   = (mode_q == 2'b11) && issued_q && is_fetch
                     && (pc == bp_addr);
        halt_force = halt_req && (state_q != S_HALT);
        cpu_ce     = 1'b0;
        if (!halt_force) begin
            case (state_q)
                S_STEP_CYC:   cpu_ce = 1'b1;
                // first cycle always enables, even if already in fetch
                S_STEP_INSTR: cpu_ce = !(issued_q && is_fetch);
                // exit cycles (breakpoint or pause) do not enable
                S_RUN:        cpu_ce = !bp_match && !pulse_q;
                default:      cpu_ce = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            issued_q <= 1'b0;
            bp_hit_q <= 1'b0;
            cyc_q    <= 32'd0;
            ins_q    <= 32'd0;
        end else begin
            if (cpu_ce) cyc_q <= cyc_q + 32'd1;
            if (cpu_ce && is_fetch) ins_q <= ins_q + 32'd1;
            if (halt_force) begin
                state_q  <= S_HALT;
                bp_hit_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pulse_q) begin
                            mode_q   <= mode;
                            issued_q <= 1'b0;
                            case (mode)
                                2'b00:   state_q <= S_STEP_CYC;
                                2'b01:   state_q <= S_STEP_INSTR;
                                default: state_q <= S_RUN;
                            endcase
                        end
                    end
                    S_STEP_CYC: state_q <= S_IDLE;
                    S_STEP_INSTR: begin
                        if (issued_q && is_fetch) state_q <= S_IDLE;
                        else issued_q <= 1'b1;
                    end
                    S_RUN: begin
                        if (bp_match) begin
                            state_q  <= S_HALT;
                            bp_hit_q <= 1'b1;
                        end else if (pulse_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            issued_q <= 1'b1;
                        end
                    end
                    S_HALT: begin
                        // halt_req still high keeps us parked here
                        if (!halt_req && pulse_q) begin
                            state_q  <= S_IDLE;
                            bp_hit_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign btn_pulse   = pulse_q;
    assign bp_hit      = bp_hit_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
    assign busy        = (state_q == S_STEP_CYC) || (state_q == S_STEP_INSTR)
                         || (state_q == S_RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: vector table plus scoreboard for step/breakpoint
// runs, hand sequences for glitch, pause, halt, wrap and async reset.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [3:0]  ctrl_state = 4'd0;
    logic        halt_req = 1'b0;
    logic        cpu_ce;
    logic        btn_pulse;
    logic        busy;
    logic        bp_hit;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FETCH_STATE    (4'd0),
        .CNT_W          (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .mode       (mode),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .ctrl_state (ctrl_state),
        .halt_req   (halt_req),
        .cpu_ce     (cpu_ce),
        .btn_pulse  (btn_pulse),
        .busy       (busy),
        .bp_hit     (bp_hit),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Core model: ctrl_state walks 0..len-1 per enabled cycle, pc += 4 on
    // each enabled fetch. Setup requests are applied by this block only.
    int          len      = 3;
    int          set_gen  = 0;
    int          seen_gen = 0;
    logic [3:0]  set_st   = 4'd0;
    logic [31:0] set_pc   = 32'd0;
    int          ce_total = 0;
    int          pulses   = 0;
    logic        ce_s;

    always @(posedge clk) begin
        ce_s = cpu_ce;
        if (btn_pulse) pulses++;
        #1;
        if (ce_s) begin
            ce_total++;
            if (ctrl_state == 4'd0) pc = pc + 32'd4;
            ctrl_state = (int'(ctrl_state) == len - 1) ? 4'd0
                                                       : ctrl_state + 4'd1;
        end
        if (set_gen != seen_gen) begin
            seen_gen   = set_gen;
            ctrl_state = set_st;
            pc         = set_pc;
        end
    end

    task automatic setup_core(input int l, input logic [3:0] st,
                              input logic [31:0] p);
        len    = l;
        set_st = st;
        set_pc = p;
        set_gen++;
        repeat (2) @(negedge clk);
    endtask

    // Raise btn and wait for the debounced pulse; returns on the negedge
    // where btn_pulse is high.
    task automatic press();
        int lat;
        lat = 0;
        btn = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (btn_pulse) lat = n;
        end
        check("press_latency", 32'(lat), 32'd7);
    endtask

    task automatic release_btn();
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!busy && k < 4) begin
            @(negedge clk);
            k++;
        end
        check({name, "_start"}, 32'(busy), 32'd1);
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_end"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  md;
        int          l;
        logic [3:0]  st;
        logic [31:0] pc0;
        logic [31:0] bp;
        int          exp_ce;
        int          exp_ins;
        logic        exp_bp;
    } vec_t;

    typedef struct {
        int   ce;
        int   ins;
        logic bp;
    } exp_t;

    vec_t        tv[7];
    exp_t        sb[$];
    exp_t        e;
    int          exp_cyc = 0;
    int          exp_ins = 0;
    int          ce0;
    int          p0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{2'b00, 3, 4'd0, 32'h0, 32'h0,  1, 1, 1'b0};
        tv[1] = '{2'b01, 5, 4'd0, 32'h0, 32'h0,  5, 1, 1'b0};
        tv[2] = '{2'b01, 3, 4'd1, 32'h0, 32'h0,  2, 0, 1'b0};
        tv[3] = '{2'b00, 3, 4'd2, 32'h0, 32'h0,  1, 0, 1'b0};
        tv[4] = '{2'b11, 3, 4'd0, 32'h0, 32'h10, 12, 4, 1'b1};
        tv[5] = '{2'b11, 2, 4'd0, 32'h8, 32'h14, 6, 3, 1'b1};
        tv[6] = '{2'b01, 4, 4'd0, 32'h0, 32'h0,  4, 1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_pulse", 32'(btn_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bp", 32'(bp_hit), 32'd0);
        check("rst_cyc", cycle_count, 32'd0);
        check("rst_ins", instr_count, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            mode    = tv[i].md;
            bp_addr = tv[i].bp;
            setup_core(tv[i].l, tv[i].st, tv[i].pc0);
            sb.push_back('{tv[i].exp_ce, tv[i].exp_ins, tv[i].exp_bp});
            ce0 = ce_total;
            press();
            wait_done($sformatf("v%0d", i));
            e = sb.pop_front();
            exp_cyc += e.ce;
            exp_ins += e.ins;
            check($sformatf("v%0d_ce_cycles", i), 32'(ce_total - ce0),
                  32'(e.ce));
            check($sformatf("v%0d_cyc", i), cycle_count, 32'(exp_cyc));
            check($sformatf("v%0d_ins", i), instr_count, 32'(exp_ins));
            check($sformatf("v%0d_bp", i), 32'(bp_hit), 32'(e.bp));
            check($sformatf("v%0d_ce_off", i), 32'(cpu_ce), 32'd0);
            release_btn();
            if (e.bp) begin
                press();
                @(negedge clk);
                check($sformatf("v%0d_bp_clear", i), 32'(bp_hit), 32'd0);
                check($sformatf("v%0d_bp_idle", i), 32'(busy), 32'd0);
                release_btn();
            end
        end

        // free run, glitch rejection, pause, mode change ignored in RUN
        mode = 2'b10;
        setup_core(3, 4'd0, 32'h0);
        press();
        @(negedge clk);
        check("run_start", 32'(busy), 32'd1);
        release_btn();
        p0 = pulses;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_no_pulse", 32'(pulses - p0), 32'd0);
        check("glitch_busy", 32'(busy), 32'd1);
        check("glitch_ce", 32'(cpu_ce), 32'd1);
        mode = 2'b00;
        repeat (3) @(negedge clk);
        check("mode_chg_run", 32'(busy), 32'd1);
        press();
        check("pause_ce", 32'(cpu_ce), 32'd0);
        @(negedge clk);
        check("pause_idle", 32'(busy), 32'd0);
        release_btn();
        check("pause_stays", 32'(busy), 32'd0);
        ce0 = ce_total;
        press();
        wait_done("step_after_run");
        check("step_after_run_ce", 32'(ce_total - ce0), 32'd1);
        release_btn();

        // halt_req coincident with a button pulse during RUN
        mode = 2'b10;
        press();
        @(negedge clk);
        check("run2_start", 32'(busy), 32'd1);
        release_btn();
        press();
        halt_req = 1'b1;
        #1;
        check("halt_ce", 32'(cpu_ce), 32'd0);
        @(negedge clk);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_bp", 32'(bp_hit), 32'd0);
        check("halt_ce_after", 32'(cpu_ce), 32'd0);
        release_btn();
        press();
        @(negedge clk);
        check("halt_ignore", 32'(busy), 32'd0);
        release_btn();
        halt_req = 1'b0;
        @(negedge clk);
        press();
        repeat (2) @(negedge clk);
        check("halt_exit_idle", 32'(busy), 32'd0);
        release_btn();
        press();
        @(negedge clk);
        check("restart_run", 32'(busy), 32'd1);
        release_btn();
        press();
        @(negedge clk);
        check("pause2_idle", 32'(busy), 32'd0);
        release_btn();

        // counter wrap from a preloaded all-ones value
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        check("wrap_preload", cycle_count, 32'hFFFF_FFFF);
        mode = 2'b00;
        press();
        wait_done("wrap_step");
        check("wrap_zero", cycle_count, 32'd0);
        release_btn();

        // asynchronous reset in the middle of a free run
        mode = 2'b10;
        press();
        @(negedge clk);
        release_btn();
        check("run3_ce", 32'(cpu_ce), 32'd1);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        #1;
        rst = 1'b0;
        #1;
        check("arst_ce", 32'(cpu_ce), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cyc", cycle_count, 32'd0);
        check("arst_ins", instr_count, 32'd0);
        check("arst_bp", 32'(bp_hit), 32'd0);
        check("arst_pulse", 32'(btn_pulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
